stopwatch_bcd: RTL and testbench
================================

// Module: stopwatch_bcd
// PURPOSE
//  Hundredths-resolution stopwatch producing a 4-digit packed-BCD value (SS.hh, 00.00-99.99 s).
//  Sits directly upstream of the 4-digit 7-segment multiplexing driver and feeds its 16-bit value input.
//  Two raw push-buttons (start/stop, lap/clear) are debounced and edge-detected internally.
//  Time base is derived from the board clock by a prescaler.
// PARAMETERS
//  CLK_HZ           50_000_000  clk frequency in Hz
//  TICK_HZ          100         count rate; one LSB per tick; CLK_HZ/TICK_HZ is an integer >= 2
//  DEBOUNCE_CYCLES  1_000_000   stable-level cycles required before a button edge is accepted
// PORTS
//  clk             in   1   clock, rising-edge
//  reset           in   1   synchronous, active-low
//  btn_start_stop  in   1   raw, async, active-low (0 = pressed)
//  btn_lap         in   1   raw, async, active-low (0 = pressed)
//  value           out  16  packed BCD {tens_s, units_s, tenths, hundredths}; [3:0] = hundredths
//  running         out  1   1 while in RUN or RUN_LAP
//  overflow        out  1   sticky; set on wrap 99.99 -> 00.00
// BEHAVIOUR
//  Reset: reset is sampled low -> state IDLE; count, lap_reg, prescaler = 0; value=16'h0000,
//   running=0, overflow=0; debouncers load the released level (1); no press pulse for >= DEBOUNCE_CYCLES+2.
//   Reset mid-operation wins over every other event in that cycle; in-flight presses are discarded.
//  Debounce: 2-FF sync; the stable counter restarts on any level change. A 1-cycle press pulse fires when
//   the synced level has been 0 for DEBOUNCE_CYCLES cycles after a stable 1. The release generates no pulse.
//   Latency from raw fall to pulse = DEBOUNCE_CYCLES+2 clk.
//  Prescaler: counts 0..CLK_HZ/TICK_HZ-1 only in RUN/RUN_LAP and wraps. tick=1 in the terminal-count cycle.
//   It holds its value in PAUSE (resume keeps phase) and is zeroed in IDLE.
//  Count: 4 BCD digits with a cascaded carry, each digit 0-9. On tick, hundredths increments.
//   A digit at 9 wraps to 0 and carries to the next digit. 99.99 + tick -> 00.00, overflow<=1, keep running.
//   Digits never take values A-F.
//  FSM (ss = start/stop pulse, lp = lap pulse):
//   IDLE:    ss -> RUN; lp -> IDLE (no-op)
//   RUN:     ss -> PAUSE; lp -> RUN_LAP, lap_reg <= count (pre-increment value if tick in same cycle)
//   RUN_LAP: ss -> PAUSE; lp -> RUN
//   PAUSE:   ss -> RUN; lp -> IDLE with count, prescaler, overflow cleared
//   ss and lp in the same cycle: ss is taken and lp is dropped.
//  Tick in the same cycle as ss in RUN/RUN_LAP: the increment is applied, then the stop takes effect.
//  value = lap_reg in RUN_LAP, else count. It is driven from registers only (no comb path from ports).
//   It changes 1 clk after the tick cycle.
//  running = (state==RUN||state==RUN_LAP), registered with the state.
// STRUCTURE
//  Package stopwatch_pkg: state enum {IDLE,RUN,RUN_LAP,PAUSE}, bcd_digit_t (4-bit), BCD_MAX=4'd9,
//   PRESCALE_MAX derived from CLK_HZ/TICK_HZ.
//  Sub-module btn_debounce (param DEBOUNCE_CYCLES; clk, reset, btn_n -> press pulse), instantiated twice.
//  Prescaler, BCD cascade and FSM stay in this module.
// TESTING (bench params: CLK_HZ=1000, TICK_HZ=100 -> 10 clk/tick, DEBOUNCE_CYCLES=4)
//  1. Hold reset=0 for 3 clk, then release -> value=16'h0000, running=0, overflow=0.
//     Chattering btn (1-clk glitches) -> no pulse.
//  2. Press ss -> pulse 6 clk after the fall, running=1. After 25 ticks -> value=16'h0025.
//     After a further 75 ticks -> 16'h0100.
//  3. Preload by running to 99.98, then 2 ticks -> 16'h9999 then 16'h0000, overflow=1, running=1.
//  4. In RUN at 16'h0042, press lp -> value frozen at 0042 while the internal count advances.
//     Press lp again -> value jumps to the live count.
//  5. ss to PAUSE at 16'h0310, wait 50 clk -> value still 0310. ss -> resumes; the first tick comes
//     after the remaining prescaler cycles. Pause again, then lp -> 16'h0000, overflow=0, IDLE.
//  6. ss and lp pulses in the same cycle in RUN -> PAUSE, no lap latch.
//     reset=0 mid-RUN with a tick pending -> all outputs zero the next clk.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared types, constants and BCD helpers for the hundredths stopwatch.
package stopwatch_pkg;

    typedef enum logic [1:0] {IDLE, RUN, RUN_LAP, PAUSE} sw_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t  BCD_MAX      = 4'd9;
    localparam int unsigned NUM_DIGITS   = 4;
    localparam int unsigned VALUE_W      = NUM_DIGITS * 4;
    localparam int unsigned DEF_CLK_HZ   = 50_000_000;
    localparam int unsigned DEF_TICK_HZ  = 100;

    function automatic int unsigned prescale_max(input int unsigned clk_hz,
                                                 input int unsigned tick_hz);
        return (clk_hz / tick_hz) - 1;
    endfunction

    localparam int unsigned PRESCALE_MAX = prescale_max(DEF_CLK_HZ, DEF_TICK_HZ);

    // Ripple-carry increment across the packed BCD digits; 9999 wraps to 0000.
    function automatic logic [VALUE_W-1:0] bcd_inc(input logic [VALUE_W-1:0] v);
        logic [VALUE_W-1:0] r;
        logic               carry;
        bcd_digit_t         d;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            d = v[i*4 +: 4];
            if (carry) begin
                if (d >= BCD_MAX) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = d + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_bcd_debounce.sv
// Push-button conditioner: 2-FF synchronizer, stable-level counter, one-cycle press pulse.
module btn_debounce
    import stopwatch_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_n,
    output logic press
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    // Accept a new level only after it has persisted; only the falling edge pulses.
    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync1 <= btn_n;
            sync2 <= sync1;
            press <= 1'b0;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable <= sync2;
                cnt    <= '0;
                press  <= ~sync2;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_bcd.sv
// Hundredths stopwatch with lap hold; drives a packed-BCD SS.hh value to the display driver.
module stopwatch_bcd
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ          = DEF_CLK_HZ,
    parameter int unsigned TICK_HZ         = DEF_TICK_HZ,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_start_stop,
    input  logic        btn_lap,
    output logic [15:0] value,
    output logic        running,
    output logic        overflow
);

    localparam int unsigned PSC_MAX = prescale_max(CLK_HZ, TICK_HZ);
    localparam int unsigned PSC_W   = $clog2(PSC_MAX + 1);

    sw_state_t          state, state_n;
    logic [PSC_W-1:0]   presc, presc_n;
    logic [VALUE_W-1:0] count, count_n;
    logic [VALUE_W-1:0] lap, lap_n;
    logic [VALUE_W-1:0] value_n;
    logic               running_n;
    logic               overflow_n;
    logic               active;
    logic               tick;
    logic               ss;
    logic               lp;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_ss (
        .clk   (clk),
        .reset (reset),
        .btn_n (btn_start_stop),
        .press (ss)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_lp (
        .clk   (clk),
        .reset (reset),
        .btn_n (btn_lap),
        .press (lp)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            presc    <= '0;
            count    <= '0;
            lap      <= '0;
            value    <= '0;
            running  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            state    <= state_n;
            presc    <= presc_n;
            count    <= count_n;
            lap      <= lap_n;
            value    <= value_n;
            running  <= running_n;
            overflow <= overflow_n;
        end
    end

    // Time base and count advance first, then button events pick the next state.
    always_comb begin
        state_n    = state;
        presc_n    = presc;
        count_n    = count;
        lap_n      = lap;
        overflow_n = overflow;
        active     = (state == RUN) || (state == RUN_LAP);
        tick       = active && (presc == PSC_W'(PSC_MAX));

        if (active) begin
            presc_n = tick ? '0 : presc + PSC_W'(1);
            if (tick) begin
                count_n = bcd_inc(count);
                if (count == 16'h9999) begin
                    overflow_n = 1'b1;
                end
            end
        end else if (state == IDLE) begin
            presc_n = '0;
        end

        case (state)
            IDLE: begin
                if (ss) state_n = RUN;
            end
            RUN: begin
                if (ss) begin
                    state_n = PAUSE;
                end else if (lp) begin
                    state_n = RUN_LAP;
                    lap_n   = count;
                end
            end
            RUN_LAP: begin
                if (ss) begin
                    state_n = PAUSE;
                end else if (lp) begin
                    state_n = RUN;
                end
            end
            PAUSE: begin
                if (ss) begin
                    state_n = RUN;
                end else if (lp) begin
                    state_n    = IDLE;
                    count_n    = '0;
                    presc_n    = '0;
                    overflow_n = 1'b0;
                end
            end
            default: state_n = IDLE;
        endcase

        running_n = (state_n == RUN) || (state_n == RUN_LAP);
        value_n   = (state_n == RUN_LAP) ? lap_n : count_n;
    end

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Step-table bench for stopwatch_bcd: a 10-clk/tick unit plus a 2-clk/tick unit for the wrap case.
module tb_stopwatch_bcd;

    typedef enum int {OP_WAIT, OP_FALL, OP_RISE, OP_RST, OP_RSTREL} op_t;

    typedef struct {
        op_t         op;
        int          n;
        logic [1:0]  btn;
        logic        sel;
        logic        chk;
        logic [15:0] value;
        logic        running;
        logic        overflow;
    } step_t;

    typedef struct {
        logic [15:0] value;
        logic        running;
        logic        overflow;
        logic        sel;
        int          idx;
    } exp_t;

    localparam logic [1:0] NB = 2'b00;
    localparam logic [1:0] SS = 2'b01;
    localparam logic [1:0] LP = 2'b10;
    localparam logic [1:0] BOTH = 2'b11;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ss1 = 1'b1, lp1 = 1'b1, ss2 = 1'b1, lp2 = 1'b1;
    logic [15:0] value1, value2;
    logic        running1, running2, overflow1, overflow2;

    int          checks = 0;
    int          failures = 0;
    step_t       steps[$];
    exp_t        sb[$];

    always #5 clk = ~clk;

    stopwatch_bcd #(.CLK_HZ(1000), .TICK_HZ(100), .DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .btn_start_stop(ss1), .btn_lap(lp1),
        .value(value1), .running(running1), .overflow(overflow1)
    );

    stopwatch_bcd #(.CLK_HZ(200), .TICK_HZ(100), .DEBOUNCE_CYCLES(4)) dut_fast (
        .clk(clk), .reset(reset), .btn_start_stop(ss2), .btn_lap(lp2),
        .value(value2), .running(running2), .overflow(overflow2)
    );

    task automatic check(input string name, input int idx, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic void add(input op_t op, input int n, input logic [1:0] btn,
                                input logic sel, input logic chk, input logic [15:0] v,
                                input logic r, input logic o);
        step_t s;
        s.op = op; s.n = n; s.btn = btn; s.sel = sel; s.chk = chk;
        s.value = v; s.running = r; s.overflow = o;
        steps.push_back(s);
    endfunction

    task automatic drive_btn(input logic sel, input logic [1:0] btn, input logic lvl);
        if (!sel) begin
            if (btn[0]) ss1 = lvl;
            if (btn[1]) lp1 = lvl;
        end else begin
            if (btn[0]) ss2 = lvl;
            if (btn[1]) lp2 = lvl;
        end
    endtask

    initial begin
        step_t s;
        exp_t  e;

        // Unit 0: 10 clk per tick; RUN entered 7 edges after a fall.
        add(OP_FALL, 6, SS, 0, 1, 16'h0000, 0, 0);
        add(OP_WAIT, 1, NB, 0, 1, 16'h0000, 1, 0);
        add(OP_RISE, 7, SS, 0, 1, 16'h0000, 1, 0);
        add(OP_WAIT, 243, NB, 0, 1, 16'h0025, 1, 0);
        add(OP_WAIT, 750, NB, 0, 1, 16'h0100, 1, 0);
        add(OP_WAIT, 3, NB, 0, 0, 16'h0000, 0, 0);
        add(OP_FALL, 7, LP, 0, 1, 16'h0100, 1, 0);   // lap on a tick edge keeps pre-increment
        add(OP_RISE, 7, LP, 0, 1, 16'h0100, 1, 0);
        add(OP_WAIT, 83, NB, 0, 1, 16'h0100, 1, 0);
        add(OP_FALL, 7, LP, 0, 1, 16'h0110, 1, 0);
        add(OP_RISE, 7, LP, 0, 1, 16'h0111, 1, 0);
        add(OP_WAIT, 9, NB, 0, 0, 16'h0000, 0, 0);
        add(OP_FALL, 7, SS, 0, 1, 16'h0113, 0, 0);   // stop on a tick edge applies the tick
        add(OP_RISE, 7, SS, 0, 1, 16'h0113, 0, 0);
        add(OP_WAIT, 50, NB, 0, 1, 16'h0113, 0, 0);
        add(OP_FALL, 7, SS, 0, 1, 16'h0113, 1, 0);
        add(OP_RISE, 7, SS, 0, 1, 16'h0113, 1, 0);
        add(OP_WAIT, 14, NB, 0, 1, 16'h0115, 1, 0);
        add(OP_FALL, 7, SS, 0, 1, 16'h0115, 0, 0);   // pause with prescaler at 8
        add(OP_RISE, 7, SS, 0, 1, 16'h0115, 0, 0);
        add(OP_FALL, 7, SS, 0, 1, 16'h0115, 1, 0);
        add(OP_WAIT, 1, NB, 0, 1, 16'h0115, 1, 0);
        add(OP_WAIT, 1, NB, 0, 1, 16'h0116, 1, 0);   // remaining phase: tick 2 clk after resume
        add(OP_RISE, 7, SS, 0, 1, 16'h0116, 1, 0);
        add(OP_FALL, 7, SS, 0, 1, 16'h0117, 0, 0);
        add(OP_RISE, 7, SS, 0, 1, 16'h0117, 0, 0);
        add(OP_FALL, 7, LP, 0, 1, 16'h0000, 0, 0);
        add(OP_RISE, 7, LP, 0, 1, 16'h0000, 0, 0);
        add(OP_FALL, 7, SS, 0, 1, 16'h0000, 1, 0);
        add(OP_RISE, 7, SS, 0, 0, 16'h0000, 0, 0);
        add(OP_WAIT, 16, NB, 0, 1, 16'h0002, 1, 0);
        add(OP_FALL, 7, BOTH, 0, 1, 16'h0003, 0, 0); // simultaneous: stop wins, no lap
        add(OP_RISE, 7, BOTH, 0, 1, 16'h0003, 0, 0);
        add(OP_FALL, 7, SS, 0, 1, 16'h0003, 1, 0);
        add(OP_RISE, 7, SS, 0, 1, 16'h0003, 1, 0);
        add(OP_WAIT, 2, NB, 0, 1, 16'h0003, 1, 0);
        add(OP_RST, 1, NB, 0, 1, 16'h0000, 0, 0);    // reset with a tick pending
        add(OP_RSTREL, 20, NB, 0, 1, 16'h0000, 0, 0);
        // Unit 1: 2 clk per tick, run to the 99.99 wrap.
        add(OP_FALL, 7, SS, 1, 1, 16'h0000, 1, 0);
        add(OP_RISE, 7, SS, 1, 0, 16'h0000, 0, 0);
        add(OP_WAIT, 19989, NB, 1, 1, 16'h9998, 1, 0);
        add(OP_WAIT, 2, NB, 1, 1, 16'h9999, 1, 0);
        add(OP_WAIT, 2, NB, 1, 1, 16'h0000, 1, 1);
        add(OP_WAIT, 2, NB, 1, 1, 16'h0001, 1, 1);
        add(OP_FALL, 7, SS, 1, 1, 16'h0004, 0, 1);
        add(OP_RISE, 7, SS, 1, 1, 16'h0004, 0, 1);
        add(OP_FALL, 7, LP, 1, 1, 16'h0000, 0, 0);

        // Reset held for 3 clk.
        cycles(3);
        check("rst_value", -1, value1, 16'h0000);
        check("rst_running", -1, 16'(running1), 16'h0000);
        check("rst_overflow", -1, 16'(overflow1), 16'h0000);
        reset = 1'b1;
        cycles(8);

        // Chatter: single-cycle lows must not register.
        for (int k = 0; k < 4; k++) begin
            ss1 = 1'b0; cycles(1);
            ss1 = 1'b1; cycles(2);
        end
        cycles(10);
        check("chatter_running", -1, 16'(running1), 16'h0000);
        // One cycle short of the debounce window.
        ss1 = 1'b0; cycles(3);
        ss1 = 1'b1; cycles(10);
        check("short_press_running", -1, 16'(running1), 16'h0000);
        check("short_press_value", -1, value1, 16'h0000);

        for (int i = 0; i < steps.size(); i++) begin
            s = steps[i];
            case (s.op)
                OP_FALL:   drive_btn(s.sel, s.btn, 1'b0);
                OP_RISE:   drive_btn(s.sel, s.btn, 1'b1);
                OP_RST:    reset = 1'b0;
                OP_RSTREL: reset = 1'b1;
                default:   ;
            endcase
            if (s.chk) begin
                e.value = s.value; e.running = s.running; e.overflow = s.overflow;
                e.sel = s.sel; e.idx = i;
                sb.push_back(e);
            end
            cycles(s.n);
            if (s.chk) begin
                e = sb.pop_front();
                check("value", e.idx, e.sel ? value2 : value1, e.value);
                check("running", e.idx, 16'(e.sel ? running2 : running1), 16'(e.running));
                check("overflow", e.idx, 16'(e.sel ? overflow2 : overflow1), 16'(e.overflow));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
